// File: rtl/wb_pattern_master.sv
// Wishbone burst master that writes seed-derived patterns and read-checks them,
// counting mismatches, so SDRAM traffic is self-checking without a host scoreboard.
module wb_pattern_master #(
    parameter int APP_AW  = 26,
    parameter int APP_DW  = 32,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_resetn,
    input  logic                      sdr_init_done,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APP_AW-1:0]         cmd_addr,
    input  logic [$clog2(MAX_LEN):0]  cmd_len,
    input  logic [APP_DW-1:0]         cmd_seed,
    output logic                      done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [15:0]               err_cnt,
    output logic [APP_AW-1:0]         first_err_addr,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [APP_AW-1:0]         wb_addr_o,
    output logic [APP_DW-1:0]         wb_dat_o,
    output logic [APP_DW/8-1:0]       wb_sel_o,
    output logic [2:0]                wb_cti_o,
    input  logic                      wb_ack_i,
    input  logic [APP_DW-1:0]         wb_dat_i
);

    localparam int LW   = $clog2(MAX_LEN) + 1;
    localparam int WW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int MINW = (APP_AW < APP_DW) ? APP_AW : APP_DW;
    localparam logic [WW-1:0] TO_VAL   = WW'(TIMEOUT);
    localparam logic [2:0]    CTI_INCR = 3'b010;
    localparam logic [2:0]    CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [APP_AW-1:0]   addr_q, addr_d;
    logic [APP_DW-1:0]   dat_q, dat_d;
    logic [APP_DW/8-1:0] sel_q, sel_d;
    logic [2:0]          cti_q, cti_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                to_err_q, to_err_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [APP_AW-1:0]   ferr_q, ferr_d;
    logic [LW-1:0]       k_q, k_d;
    logic [WW-1:0]       wdog_q, wdog_d;

    // Command fields, loaded only on accept.
    logic [APP_DW-1:0]   seed_q;
    logic [LW-1:0]       len_q;
    logic                wr_q;

    logic                accept;
    logic [LW-1:0]       len_eff;
    logic [APP_AW-1:0]   start_addr;
    logic [APP_AW-1:0]   nxt_addr;

    function automatic logic [APP_DW-1:0] pattern(input logic [APP_DW-1:0] seed,
                                                  input logic [APP_AW-1:0] addr);
        logic [APP_DW-1:0] ext;
        ext            = '0;
        ext[MINW-1:0]  = addr[MINW-1:0];
        return seed ^ ext;
    endfunction

    always_comb begin
        state_d    = state_q;
        rdy_d      = 1'b0;
        cyc_d      = 1'b0;
        we_d       = 1'b0;
        addr_d     = '0;
        dat_d      = '0;
        sel_d      = '0;
        cti_d      = 3'b000;
        done_d     = 1'b0;
        to_err_d   = to_err_q;
        err_cnt_d  = err_cnt_q;
        ferr_d     = ferr_q;
        k_d        = k_q;
        wdog_d     = wdog_q;
        accept     = 1'b0;
        nxt_addr   = addr_q + APP_AW'(4);
        start_addr = cmd_addr & ~APP_AW'(3);
        if (cmd_len == '0)
            len_eff = LW'(1);
        else if (cmd_len > LW'(MAX_LEN))
            len_eff = LW'(MAX_LEN);
        else
            len_eff = cmd_len;

        case (state_q)
            S_IDLE: begin
                rdy_d = sdr_init_done;
                if (cmd_valid && rdy_q) begin
                    accept  = 1'b1;
                    state_d = S_BUS;
                    rdy_d   = 1'b0;
                    k_d     = '0;
                    wdog_d  = '0;
                    cyc_d   = 1'b1;
                    we_d    = cmd_write;
                    addr_d  = start_addr;
                    sel_d   = '1;
                    cti_d   = (len_eff == LW'(1)) ? CTI_EOB : CTI_INCR;
                    dat_d   = cmd_write ? pattern(cmd_seed, start_addr) : '0;
                end
            end
            S_BUS: begin
                cyc_d  = 1'b1;
                we_d   = wr_q;
                addr_d = addr_q;
                dat_d  = dat_q;
                sel_d  = sel_q;
                cti_d  = cti_q;
                if (wb_ack_i) begin
                    wdog_d = '0;
                    if (!wr_q && (wb_dat_i != pattern(seed_q, addr_q))) begin
                        if (err_cnt_q != 16'hFFFF)
                            err_cnt_d = err_cnt_q + 16'd1;
                        if (err_cnt_q == 16'd0)
                            ferr_d = addr_q;
                    end
                    if (k_q == len_q - LW'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d    = k_q + LW'(1);
                        addr_d = nxt_addr;
                        dat_d  = wr_q ? pattern(seed_q, nxt_addr) : '0;
                        cti_d  = (k_q + LW'(2) == len_q) ? CTI_EOB : CTI_INCR;
                    end
                end else if (wdog_q == TO_VAL) begin
                    // Abandon the remaining beats; a late ack would be ignored.
                    to_err_d = 1'b1;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
                if (state_d == S_DONE) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    addr_d = '0;
                    dat_d  = '0;
                    sel_d  = '0;
                    cti_d  = 3'b000;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rdy_d   = sdr_init_done;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cti_q     <= 3'b000;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            to_err_q  <= 1'b0;
            err_cnt_q <= '0;
            ferr_q    <= '0;
            k_q       <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cti_q     <= cti_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            to_err_q  <= to_err_d;
            err_cnt_q <= err_cnt_d;
            ferr_q    <= ferr_d;
            k_q       <= k_d;
            wdog_q    <= wdog_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            seed_q <= cmd_seed;
            len_q  <= len_eff;
            wr_q   <= cmd_write;
        end
    end

    assign cmd_ready      = rdy_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign timeout_err    = to_err_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = ferr_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_cti_o       = cti_q;

endmodule

// File: tb/tb_wb_pattern_master.sv
// Directed bench for wb_pattern_master: bursts, pattern checking, watchdog and reset.
module tb_wb_pattern_master;

    logic        clk = 1'b0;
    logic        wb_resetn;
    logic        sdr_init_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [25:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic        done, busy, timeout_err;
    logic [15:0] err_cnt;
    logic [25:0] first_err_addr;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [25:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    int total = 0;
    int bad   = 0;

    wb_pattern_master dut (
        .wb_clk_i(clk), .wb_resetn(wb_resetn), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .done(done), .busy(busy), .timeout_err(timeout_err), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i),
        .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic w, input logic [25:0] a,
                         input logic [4:0] len, input logic [31:0] seed);
        chk({tag, "_rdy"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_seed  = seed;
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_cyc"}, wb_cyc_o, 1);
        chk({tag, "_we"}, wb_we_o, w);
        chk({tag, "_rdylow"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_sel"}, wb_sel_o, 4'hF);
    endtask

    // Checks the presented beat on every cycle (including stall cycles), then acks it.
    task automatic beat(input string tag, input logic [25:0] ea, input logic [31:0] ed,
                        input logic [2:0] ec, input logic [31:0] rd, input int stall);
        for (int s = 0; s <= stall; s++) begin
            chk({tag, "_stb"}, wb_stb_o, 1);
            chk({tag, "_addr"}, wb_addr_o, ea);
            chk({tag, "_dat"}, wb_dat_o, ed);
            chk({tag, "_cti"}, wb_cti_o, ec);
            if (s == stall) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rd;
            end
            tick();
            wb_ack_i = 1'b0;
            wb_dat_i = '0;
        end
    endtask

    task automatic finish_burst(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_cycoff"}, wb_cyc_o, 0);
        chk({tag, "_busyd"}, busy, 1);
        tick();
        chk({tag, "_done0"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_rdy2"}, cmd_ready, 1);
    endtask

    initial begin
        int n;
        logic [25:0] a;
        wb_resetn     = 1'b0;
        sdr_init_done = 1'b0;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        cmd_seed      = '0;
        wb_ack_i      = 1'b0;
        wb_dat_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        wb_resetn = 1'b1;
        tick();
        chk("init_low_rdy", cmd_ready, 0);
        sdr_init_done = 1'b1;
        tick();
        chk("init_rdy", cmd_ready, 1);

        issue("w4", 1'b1, 26'h100, 5'd4, 32'hA5A5_0000);
        beat("w4b0", 26'h100, 32'hA5A5_0100, 3'b010, 32'h0, 0);
        beat("w4b1", 26'h104, 32'hA5A5_0104, 3'b010, 32'h0, 0);
        beat("w4b2", 26'h108, 32'hA5A5_0108, 3'b010, 32'h0, 0);
        beat("w4b3", 26'h10C, 32'hA5A5_010C, 3'b111, 32'h0, 0);
        finish_burst("w4");

        issue("len1", 1'b1, 26'h10, 5'd1, 32'h0);
        beat("len1b0", 26'h10, 32'h10, 3'b111, 32'h0, 0);
        finish_burst("len1");
        issue("len0", 1'b1, 26'h20, 5'd0, 32'hFFFF_0000);
        beat("len0b0", 26'h20, 32'hFFFF_0020, 3'b111, 32'h0, 0);
        finish_burst("len0");

        issue("wrap", 1'b1, 26'h3FF_FFFF, 5'd2, 32'h0);
        beat("wrapb0", 26'h3FF_FFFC, 32'h03FF_FFFC, 3'b010, 32'h0, 0);
        beat("wrapb1", 26'h000_0000, 32'h0, 3'b111, 32'h0, 0);
        finish_burst("wrap");

        issue("rd1", 1'b0, 26'h200, 5'd4, 32'h1234_0000);
        beat("rd1b0", 26'h200, 32'h0, 3'b010, 32'h1234_0200, 0);
        beat("rd1b1", 26'h204, 32'h0, 3'b010, 32'h1234_0204, 0);
        beat("rd1b2", 26'h208, 32'h0, 3'b010, 32'hDEAD_BEEF, 0);
        beat("rd1b3", 26'h20C, 32'h0, 3'b111, 32'h1234_020C, 0);
        finish_burst("rd1");
        chk("rd1_errcnt", err_cnt, 1);
        chk("rd1_ferr", first_err_addr, 26'h208);

        issue("rd2", 1'b0, 26'h300, 5'd2, 32'h0);
        beat("rd2b0", 26'h300, 32'h0, 3'b010, 32'h0000_0001, 0);
        beat("rd2b1", 26'h304, 32'h0, 3'b111, 32'h0000_0304, 0);
        finish_burst("rd2");
        chk("rd2_errcnt", err_cnt, 2);
        chk("rd2_ferr", first_err_addr, 26'h208);

        issue("rd16", 1'b0, 26'h400, 5'd16, 32'hCAFE_0000);
        for (int k = 0; k < 16; k++) begin
            a = 26'h400 + 26'(4 * k);
            beat("rd16b", a, 32'h0, (k < 15) ? 3'b010 : 3'b111, 32'hCAFE_0000 ^ {6'h0, a}, 1);
        end
        finish_burst("rd16");
        chk("rd16_errcnt", err_cnt, 2);
        chk("rd16_to", timeout_err, 0);

        issue("to", 1'b0, 26'h0, 5'd2, 32'h0);
        n = 0;
        while (!done && n < 1100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 1024);
        chk("to_flag", timeout_err, 1);
        chk("to_cyc", wb_cyc_o, 0);
        chk("to_errcnt", err_cnt, 2);
        tick();
        chk("to_rdy", cmd_ready, 1);

        issue("mr", 1'b1, 26'h500, 5'd4, 32'h0);
        beat("mrb0", 26'h500, 32'h500, 3'b010, 32'h0, 0);
        chk("mr_cyc_pre", wb_cyc_o, 1);
        wb_resetn     = 1'b0;
        sdr_init_done = 1'b0;
        #1;
        chk("mr_cyc", wb_cyc_o, 0);
        chk("mr_stb", wb_stb_o, 0);
        chk("mr_busy", busy, 0);
        chk("mr_errcnt", err_cnt, 0);
        chk("mr_ferr", first_err_addr, 0);
        chk("mr_to", timeout_err, 0);
        chk("mr_addr", wb_addr_o, 0);
        tick();
        wb_resetn = 1'b1;
        cmd_valid = 1'b1;
        repeat (3) tick();
        chk("mr_rdy_low", cmd_ready, 0);
        chk("mr_ignored", wb_cyc_o, 0);
        chk("mr_ignbusy", busy, 0);
        cmd_valid     = 1'b0;
        sdr_init_done = 1'b1;
        tick();
        chk("mr_rdy", cmd_ready, 1);

        issue("ta", 1'b1, 26'h40, 5'd2, 32'h0);
        repeat (1023) tick();
        chk("ta_cyc_hold", wb_cyc_o, 1);
        chk("ta_addr_hold", wb_addr_o, 26'h40);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("ta_cyc", wb_cyc_o, 1);
        chk("ta_nodone", done, 0);
        chk("ta_flag", timeout_err, 0);
        beat("tab1", 26'h44, 32'h44, 3'b111, 32'h0, 0);
        finish_burst("ta");
        chk("ta_flag_end", timeout_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
